// File: rtl/fpadd_pkg.sv
// Shared types for the FP32 adder request sequencer: FSM states, the qNaN
// substitute and the operand FIFO entry layout.
package fpadd_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    // Tag capacity of a FIFO entry; the sequencer's TAG_W must not exceed it.
    localparam int TAG_MAX = 4;

    typedef struct packed {
        logic [31:0]        a;
        logic [31:0]        b;
        logic [TAG_MAX-1:0] tag;
    } fifo_entry_t;

endpackage

// File: rtl/fpadd_seq_fifo.sv
// Synchronous FIFO with show-ahead head output; DEPTH must be a power of 2.
module fpadd_seq_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + 1'b1;
            if (pop && !empty)
                rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/fpadd_seq.sv
// Request sequencer around a multi-cycle FP32 adder: buffers operand pairs,
// issues one at a time, waits for done (or times out) and returns tagged sums.
module fpadd_seq
    import fpadd_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             fa_start,
    output logic [31:0]      fa_a,
    output logic [31:0]      fa_b,
    input  logic [31:0]      fa_sum,
    input  logic             fa_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_timeout,
    output logic             busy
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t           state, nxt;
    fifo_entry_t      wr_entry, head;
    logic             full, empty, push, pop;
    logic [CW-1:0]    cnt;
    logic             timeout_hit;
    logic [TAG_W-1:0] hold_tag;

    assign in_ready    = !full;
    assign push        = in_valid && !full;
    assign timeout_hit = (cnt == CW'(TIMEOUT));

    always_comb begin
        wr_entry     = '0;
        wr_entry.a   = in_a;
        wr_entry.b   = in_b;
        wr_entry.tag = TAG_MAX'(in_tag);
    end

    fpadd_seq_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fifo_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        nxt = state;
        pop = 1'b0;
        case (state)
            S_IDLE:  if (!empty) begin
                         pop = 1'b1;
                         nxt = S_ISSUE;
                     end
            S_ISSUE: nxt = S_WAIT;
            S_WAIT:  if (fa_done || timeout_hit) nxt = S_RESP;
            S_RESP:  if (out_ready) begin
                         // Chain straight into the next issue when work is queued.
                         pop = !empty;
                         nxt = empty ? S_IDLE : S_ISSUE;
                     end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            fa_start    <= 1'b0;
            fa_a        <= '0;
            fa_b        <= '0;
            hold_tag    <= '0;
            out_sum     <= '0;
            out_timeout <= 1'b0;
            cnt         <= '0;
        end else begin
            state    <= nxt;
            // Registered so the adder never sees a path from fa_done.
            fa_start <= (nxt == S_ISSUE);
            if (pop) begin
                fa_a     <= head.a;
                fa_b     <= head.b;
                hold_tag <= head.tag[TAG_W-1:0];
            end
            case (state)
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    if (!timeout_hit)
                        cnt <= cnt + CW'(1);
                    if (fa_done) begin
                        out_sum     <= fa_sum;
                        out_timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        out_sum     <= FP32_QNAN;
                        out_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (state == S_RESP);
    assign out_tag   = hold_tag;
    assign busy      = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_fpadd_seq.sv
// Scoreboard bench for fpadd_seq with a behavioural table-driven adder model.
module tb_fpadd_seq;
    localparam int TIMEOUT = 63;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0, in_b = '0;
    logic [3:0]  in_tag = '0;
    logic        fa_start;
    logic [31:0] fa_a, fa_b;
    logic [31:0] fa_sum = '0;
    logic        fa_done = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_sum;
    logic [3:0]  out_tag;
    logic        out_timeout;
    logic        busy;

    fpadd_seq #(.DEPTH(2), .TAG_W(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .fa_start(fa_start), .fa_a(fa_a), .fa_b(fa_b), .fa_sum(fa_sum), .fa_done(fa_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_tag(out_tag),
        .out_timeout(out_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic [3:0]  tag;
        logic        to;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] op_q[$];
    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int start_cyc = 0, ov_cyc = 0, hs_cyc = -10, nb_cnt = 0, start_cnt = 0;
    bit prev_ov = 1'b0;

    int lat = 5;
    bit never = 1'b0;
    bit stale_req = 1'b0;
    int m_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed FP32 sums for the operand pairs used below.
    function automatic logic [31:0] fp_add_tab(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return 32'h40400000;
            64'h3F800000_3F800000: return 32'h40000000;
            64'h40000000_40000000: return 32'h40800000;
            64'h3FC00000_3F000000: return 32'h40000000;
            64'h40400000_3F800000: return 32'h40800000;
            default:               return 32'hDEADBEEF;
        endcase
    endfunction

    // Adder model: done goes high lat cycles after the start edge, holds until next start.
    always @(posedge clk) begin
        if (reset) begin
            m_cnt   <= 0;
            fa_done <= 1'b0;
        end else if (fa_start) begin
            fa_done <= 1'b0;
            m_cnt   <= never ? 0 : lat;
        end else if (m_cnt == 1) begin
            fa_done <= 1'b1;
            fa_sum  <= fp_add_tab(fa_a, fa_b);
            m_cnt   <= 0;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else if (stale_req) begin
            fa_done <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: compares results on handshake and issued operands on start.
    always @(negedge clk) begin
        if (out_valid && !prev_ov) ov_cyc = cyc;
        prev_ov = out_valid;
        if (out_valid && out_ready) begin
            hs_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_sum", 64'(out_sum), 64'(e.sum));
                chk("out_tag", 64'(out_tag), 64'(e.tag));
                chk("out_timeout", 64'(out_timeout), 64'(e.to));
            end
        end
        if (fa_start) begin
            start_cyc = cyc;
            start_cnt++;
            if (cyc == hs_cyc + 1) nb_cnt++;
            if (op_q.size() == 0) begin
                chk("unexpected_start", 64'(fa_start), 64'd0);
            end else begin
                chk("fa_operands", {fa_a, fa_b}, op_q.pop_front());
            end
        end
    end

    // Call at #1 after a posedge; returns the same way after acceptance.
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                        input logic [31:0] esum, input logic eto, output int c0);
        int n = 0;
        exp_t e;
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("push_wait");
        c0 = cyc;
        e.sum = esum; e.tag = tag; e.to = eto;
        exp_q.push_back(e);
        op_q.push_back({a, b});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || busy) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_started();
        int n = 0;
        while (op_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (op_q.size() != 0) fail_now("wait_start");
    endtask

    initial begin
        int c0;
        int s0;
        int n;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fa_start", 64'(fa_start), 64'd0);
        chk("rst_ab", {fa_a, fa_b}, 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_timeout", 64'(out_timeout), 64'd0);

        // Single operation with latency checks
        @(posedge clk); #1;
        push(32'h3F800000, 32'h40000000, 4'd3, 32'h40400000, 1'b0, c0);
        drain();
        chk("start_latency", 64'(start_cyc - c0), 64'd2);
        chk("out_latency", 64'(ov_cyc - c0), 64'd9);

        // FIFO full and ordering, no bubble between chained results
        nb_cnt = 0;
        push(32'h3F800000, 32'h3F800000, 4'd1, 32'h40000000, 1'b0, c0);
        push(32'h40000000, 32'h40000000, 4'd2, 32'h40800000, 1'b0, c0);
        push(32'h3FC00000, 32'h3F000000, 4'd3, 32'h40000000, 1'b0, c0);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        drain();
        chk("no_bubble", 64'(nb_cnt), 64'd2);

        // Backpressure held in RESP
        out_ready = 1'b0;
        push(32'h3F800000, 32'h40000000, 4'd5, 32'h40400000, 1'b0, c0);
        push(32'h40000000, 32'h40000000, 4'd6, 32'h40800000, 1'b0, c0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("bp_wait_valid");
        s0 = start_cnt;
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_sum", 64'(out_sum), 64'h40400000);
            chk("bp_tag", 64'(out_tag), 64'd5);
        end
        chk("bp_no_start", 64'(start_cnt - s0), 64'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        drain();

        // Timeout, then a normal operation
        never = 1'b1;
        push(32'h3F800000, 32'h3F800000, 4'd7, 32'h7FC00000, 1'b1, c0);
        wait_started();
        @(posedge clk); #1 never = 1'b0;
        push(32'h40000000, 32'h40000000, 4'd8, 32'h40800000, 1'b0, c0);
        drain();

        // Done arrives on the same cycle the counter reaches TIMEOUT
        lat = TIMEOUT;
        push(32'h40400000, 32'h3F800000, 4'd9, 32'h40800000, 1'b0, c0);
        drain();
        lat = 5;

        // Reset mid-WAIT, then stale done held while idle
        never = 1'b1;
        push(32'h3FC00000, 32'h3F000000, 4'd10, 32'h40000000, 1'b0, c0);
        wait_started();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        stale_req = 1'b1;
        exp_q.delete();
        op_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_fa_start", 64'(fa_start), 64'd0);
        chk("mid_rst_ab", {fa_a, fa_b}, 64'd0);
        chk("mid_rst_out_sum", 64'(out_sum), 64'd0);
        repeat (6) @(negedge clk);
        chk("stale_out_valid", 64'(out_valid), 64'd0);
        chk("stale_busy", 64'(busy), 64'd0);
        never = 1'b0;
        stale_req = 1'b0;
        @(posedge clk); #1;
        push(32'h3FC00000, 32'h3F000000, 4'd11, 32'h40000000, 1'b0, c0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
